sha256_padder: RTL and testbench

Message-side front end for `sha256_core`. Takes an arbitrary-length byte stream, packs it big-endian into 32-bit words, and appends SHA-256 padding: one `0x80` byte, zero fill, then the 64-bit message bit length. Drives the core's word-write port (`data`/`wr_en`/`wr_ready`) with complete 16-word blocks, so upstream logic never builds padded blocks itself.

---
 rtl/sha256_pkg.sv | 39 +++
 rtl/sha256_padder.sv | 173 +++++++++++++++++
 tb/tb_sha256_padder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared definitions for the SHA-256 message padder: the padder FSM state
// type, block geometry constants, the padding word and a helper that builds
// the final (partially filled) message word.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_EMIT_MSG,
    ST_PAD,
    ST_LEN_HI,
    ST_LEN_LO
  } padder_state_t;

  localparam int          WORDS_PER_BLOCK = 16;
  localparam int          IDX_W           = $clog2(WORDS_PER_BLOCK);
  localparam logic [3:0]  LEN_HI_IDX      = 4'd14;
  localparam logic [3:0]  LEN_LO_IDX      = 4'd15;
  localparam logic [31:0] PAD_WORD        = 32'h8000_0000;

  // Aligns the packer contents so byte 0 sits in [31:24]. `shifted` holds the
  // bytes received so far right-justified (newest in [7:0]); `lane` is the
  // lane of the newest byte. For a short final word the 0x80 marker lands in
  // the next lane and everything below it is zero. A full word (lane 3) is
  // returned unchanged; its pad is carried into the following word.
  function automatic logic [31:0] pack_final(input logic [31:0] shifted,
                                             input logic [1:0]  lane);
    logic [31:0] word;
    case (lane)
      2'd0:    word = {shifted[7:0],  8'h80, 16'h0000};
      2'd1:    word = {shifted[15:0], 8'h80, 8'h00};
      2'd2:    word = {shifted[23:0], 8'h80};
      default: word = shifted;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/sha256_padder.sv
// sha256_padder
// Byte-stream front end for sha256_core. Packs message bytes big-endian into
// 32-bit words, appends the 0x80 marker, zero fill and the 64-bit message bit
// length, and streams complete 16-word blocks into the core's word port.
//
// Ports:
//   clk       in   clock
//   reset     in   asynchronous active-high reset
//   in_data   in   [7:0] message byte
//   in_valid  in   in_data is valid
//   in_last   in   final byte of the message (qualifies in_valid)
//   in_ready  out  a byte is accepted this cycle when in_valid is high
//   data      out  [31:0] registered word presented to the core
//   wr_en     out  word transfers this cycle
//   wr_ready  in   core can accept a word
//   msg_done  out  pulse on the cycle the final length word transfers
//   busy      out  high from the first accepted byte until msg_done
module sha256_padder
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] data,
  output logic        wr_en,
  input  logic        wr_ready,
  output logic        msg_done,
  output logic        busy
);

  padder_state_t    state_q, state_d;
  logic [31:0]      shift_q, shift_d;     // byte packer, newest byte in [7:0]
  logic [1:0]       lane_q, lane_d;       // lane of the next incoming byte
  logic [31:0]      data_q, data_d;
  logic [63:0]      bitcnt_q, bitcnt_d;
  logic [IDX_W-1:0] widx_q, widx_d;       // index of the word currently in data
  logic             pad_owed_q, pad_owed_d; // 0x80 not yet emitted
  logic             last_q, last_d;       // message bytes are all in
  logic             busy_q, busy_d;

  logic             emitting;
  logic             xfer;
  logic [31:0]      shifted;
  logic [IDX_W-1:0] widx_next;

  always_comb begin
    emitting  = (state_q == ST_EMIT_MSG) || (state_q == ST_PAD) ||
                (state_q == ST_LEN_HI)   || (state_q == ST_LEN_LO);
    xfer      = emitting && wr_ready;
    shifted   = {shift_q[23:0], in_data};
    widx_next = widx_q + 1'b1;

    // Outputs are forced to their reset values while reset is asserted;
    // in_ready is the only one not already implied by the reset state.
    in_ready  = ((state_q == ST_IDLE) || (state_q == ST_ACCUM)) && !reset;
    wr_en     = xfer;
    msg_done  = (state_q == ST_LEN_LO) && wr_ready;
    data      = data_q;
    busy      = busy_q;

    state_d    = state_q;
    shift_d    = shift_q;
    lane_d     = lane_q;
    data_d     = data_q;
    bitcnt_d   = bitcnt_q;
    widx_d     = widx_q;
    pad_owed_d = pad_owed_q;
    last_d     = last_q;
    busy_d     = busy_q;

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (in_valid) begin
          busy_d   = 1'b1;
          bitcnt_d = bitcnt_q + 64'd8;
          shift_d  = shifted;
          lane_d   = lane_q + 2'd1;
          state_d  = ST_ACCUM;
          if (in_last || (lane_q == 2'd3)) begin
            data_d     = pack_final(shifted, lane_q);
            shift_d    = '0;
            lane_d     = 2'd0;
            last_d     = in_last;
            // A final byte that fills the word leaves no lane for 0x80.
            pad_owed_d = in_last && (lane_q == 2'd3);
            state_d    = ST_EMIT_MSG;
          end
        end
      end

      ST_EMIT_MSG: begin
        if (wr_ready) begin
          widx_d = widx_next;
          if (!last_q) begin
            state_d = ST_ACCUM;
          end else if (pad_owed_q) begin
            data_d  = PAD_WORD;
            state_d = ST_PAD;
          end else if (widx_next == LEN_HI_IDX) begin
            data_d  = bitcnt_q[63:32];
            state_d = ST_LEN_HI;
          end else begin
            data_d  = '0;
            state_d = ST_PAD;
          end
        end
      end

      ST_PAD: begin
        // Index 14 is only reached once; a pad word at 14 or 15 runs on
        // through the wrap into a fresh block before the length goes out.
        if (wr_ready) begin
          widx_d     = widx_next;
          pad_owed_d = 1'b0;
          if (widx_next == LEN_HI_IDX) begin
            data_d  = bitcnt_q[63:32];
            state_d = ST_LEN_HI;
          end else begin
            data_d  = '0;
          end
        end
      end

      ST_LEN_HI: begin
        if (wr_ready) begin
          widx_d  = LEN_LO_IDX;
          data_d  = bitcnt_q[31:0];
          state_d = ST_LEN_LO;
        end
      end

      ST_LEN_LO: begin
        if (wr_ready) begin
          widx_d   = '0;
          bitcnt_d = '0;
          last_d   = 1'b0;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      lane_q     <= '0;
      data_q     <= '0;
      bitcnt_q   <= '0;
      widx_q     <= '0;
      pad_owed_q <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      lane_q     <= lane_d;
      data_q     <= data_d;
      bitcnt_q   <= bitcnt_d;
      widx_q     <= widx_d;
      pad_owed_q <= pad_owed_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder
// Directed bench for sha256_padder: drives byte messages, collects every word
// transfer, and compares against hand-computed padded block sequences.
module tb_sha256_padder;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] data;
  logic        wr_en;
  logic        wr_ready;
  logic        msg_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] got_q[$];
  int          done_q[$];
  logic [31:0] exp_q[$];

  sha256_padder dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .data     (data),
    .wr_en    (wr_en),
    .wr_ready (wr_ready),
    .msg_done (msg_done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word monitor: records every transfer and the transfer index of msg_done.
  always @(negedge clk) begin
    if (wr_en) got_q.push_back(data);
    if (msg_done) done_q.push_back(wr_en ? got_q.size() - 1 : -1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_zeros(input int n);
    repeat (n) exp_q.push_back(32'h0);
  endtask

  task automatic exp_hello();
    exp_q.delete();
    exp_q.push_back(32'h68656C6C);
    exp_q.push_back(32'h6F20776F);
    exp_q.push_back(32'h726C6480);
    exp_zeros(11);
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h00000058);
  endtask

  task automatic exp_abc56();
    exp_q.delete();
    exp_q.push_back(32'h61626364); exp_q.push_back(32'h62636465);
    exp_q.push_back(32'h63646566); exp_q.push_back(32'h64656667);
    exp_q.push_back(32'h65666768); exp_q.push_back(32'h66676869);
    exp_q.push_back(32'h6768696A); exp_q.push_back(32'h68696A6B);
    exp_q.push_back(32'h696A6B6C); exp_q.push_back(32'h6A6B6C6D);
    exp_q.push_back(32'h6B6C6D6E); exp_q.push_back(32'h6C6D6E6F);
    exp_q.push_back(32'h6D6E6F70); exp_q.push_back(32'h6E6F7071);
    exp_q.push_back(32'h80000000);   // index 14
    exp_zeros(1);                    // index 15
    exp_zeros(14);                   // next block 0..13
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h000001C0);
  endtask

  // Sends the bytes of s; in_last on the final byte when with_last is set.
  task automatic send_bytes(input string s, input bit with_last);
    for (int i = 0; i < s.len(); i++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) chk("in_ready_wait", {63'b0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = with_last && (i == s.len() - 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  // Runs until msg_done, optionally toggling wr_ready at random, and checks
  // that data is held across stalled cycles and busy/in_ready afterwards.
  task automatic drain(input bit stall);
    int          cyc;
    bit          seen;
    bit          prev_stall;
    logic [31:0] prev_data;
    cyc = 0; seen = 0; prev_stall = 0; prev_data = '0;
    while (!seen && cyc < 400) begin
      @(posedge clk); #1;
      if (stall) wr_ready = ($urandom_range(0, 2) != 0);
      else       wr_ready = 1'b1;
      @(negedge clk);
      if (prev_stall) chk("hold", {32'b0, data}, {32'b0, prev_data});
      prev_stall = !wr_ready && !in_ready && busy;
      prev_data  = data;
      if (msg_done) seen = 1;
      cyc++;
    end
    if (!seen) begin
      chk("done_timeout", {63'b0, msg_done}, 64'd1);
    end else begin
      chk("done_in_ready", {63'b0, in_ready}, 64'd0);
      chk("done_busy", {63'b0, busy}, 64'd1);
      @(posedge clk); #1;
      wr_ready = 1'b1;
      chk("after_busy", {63'b0, busy}, 64'd0);
      chk("after_in_ready", {63'b0, in_ready}, 64'd1);
    end
    wr_ready = 1'b1;
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), {32'b0, got_q[i]}, {32'b0, exp_q[i]});
    chk({tag, "_done_cnt"}, 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0)
      chk({tag, "_done_at"}, 64'(done_q[0]), 64'(exp_q.size() - 1));
    $display("msg %s: words=%0d done_at=%0d", tag, got_q.size(),
             (done_q.size() > 0) ? done_q[0] : -1);
    got_q.delete();
    done_q.delete();
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    wr_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_data",     {32'b0, data},     64'd0);
    chk("rst_wr_en",    {63'b0, wr_en},    64'd0);
    chk("rst_msg_done", {63'b0, msg_done}, 64'd0);
    chk("rst_busy",     {63'b0, busy},     64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {63'b0, in_ready}, 64'd1);

    // "hello world", pad inside the last message word
    exp_hello();
    send_bytes("hello world", 1);
    drain(0);
    check_words("hello");

    // 56-byte message: pad carried to index 14, extra block
    exp_abc56();
    send_bytes("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 1);
    drain(0);
    check_words("abc56");

    // 4-byte message: carried pad word, plus first-word latency
    exp_q.delete();
    exp_q.push_back(32'h61626364);
    exp_q.push_back(32'h80000000);
    exp_zeros(12);
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h00000020);
    send_bytes("abcd", 1);
    @(negedge clk);
    chk("lat_wr_en", {63'b0, wr_en}, 64'd1);
    chk("lat_data",  {32'b0, data},  64'h61626364);
    chk("lat_busy",  {63'b0, busy},  64'd1);
    drain(0);
    check_words("four");

    // Same 56-byte message with random wr_ready stalls
    exp_abc56();
    send_bytes("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 1);
    drain(1);
    check_words("abc56_stall");

    // Reset after 6 bytes, then a clean "hello world"
    send_bytes("hello ", 0);
    chk("mid_busy", {63'b0, busy}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("arst_data",     {32'b0, data},     64'd0);
    chk("arst_wr_en",    {63'b0, wr_en},    64'd0);
    chk("arst_msg_done", {63'b0, msg_done}, 64'd0);
    chk("arst_busy",     {63'b0, busy},     64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    got_q.delete();
    done_q.delete();
    exp_hello();
    send_bytes("hello world", 1);
    drain(0);
    check_words("hello_after_reset");

    // Back-to-back: "abc" then "hello world"; length must not accumulate
    exp_q.delete();
    exp_q.push_back(32'h61626380);
    exp_zeros(13);
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h00000018);
    send_bytes("abc", 1);
    drain(0);
    check_words("b2b_abc");
    exp_hello();
    send_bytes("hello world", 1);
    drain(0);
    check_words("b2b_hello");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
